alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Byte-serial command front end for an external registered ALU: collects a
// 5-byte frame, drives the operands, waits for the result and returns 3 bytes.
module alu_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_fun,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        GET_A0 = 4'd1,
        GET_A1 = 4'd2,
        GET_B0 = 4'd3,
        GET_B1 = 4'd4,
        EXEC   = 4'd5,
        WAIT   = 4'd6,
        SEND0  = 4'd7,
        SEND1  = 4'd8,
        SEND2  = 4'd9
    } state_t;

    state_t         state;
    logic [CW-1:0]  idle_cnt;
    logic [15:0]    result;
    logic [3:0]     flags;

    // Frame collection, result capture and response handshake in one FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idle_cnt  <= '0;
            result    <= 16'h0000;
            flags     <= 4'h0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            alu_fun   <= 4'h0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // Bytes arriving while a command is in flight are dropped but flagged.
            if (rx_valid && (state inside {EXEC, WAIT, SEND0, SEND1, SEND2})) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        alu_fun  <= rx_data[3:0];
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GET_A0;
                    end
                end
                GET_A0, GET_A1, GET_B0, GET_B1: begin
                    // A byte on the last allowed cycle wins over the timeout.
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        case (state)
                            GET_A0: begin
                                alu_a[7:0] <= rx_data;
                                state      <= GET_A1;
                            end
                            GET_A1: begin
                                alu_a[15:8] <= rx_data;
                                state       <= GET_B0;
                            end
                            GET_B0: begin
                                alu_b[7:0] <= rx_data;
                                state      <= GET_B1;
                            end
                            default: begin
                                alu_b[15:8] <= rx_data;
                                state       <= EXEC;
                            end
                        endcase
                    end else if (idle_cnt == CNT_LAST) begin
                        idle_cnt  <= '0;
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    state <= WAIT;
                end
                WAIT: begin
                    result   <= alu_out;
                    flags    <= alu_flags;
                    tx_data  <= alu_out[7:0];
                    tx_valid <= 1'b1;
                    state    <= SEND0;
                end
                SEND0: begin
                    if (tx_ready) begin
                        tx_data <= result[15:8];
                        state   <= SEND1;
                    end
                end
                SEND1: begin
                    if (tx_ready) begin
                        tx_data <= {4'b0000, flags};
                        state   <= SEND2;
                    end
                end
                SEND2: begin
                    if (tx_ready) begin
                        tx_data  <= 8'h00;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    idle_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: a registered ALU fixture, a frame-level reference
// model compared every cycle, directed literal scenarios and random traffic.
module tb_alu_cmd_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out = 16'h0000;
    logic [3:0]  alu_flags = 4'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy, frame_err, overrun;

    int tests = 0;
    int fails = 0;
    int ferr_seen = 0;
    bit mdl_on = 1'b0;
    logic [7:0] got[$];

    alu_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Test ALU: {flags, result}, flags = {Arith, Logic, CMP, Shift}
    function automatic logic [19:0] ref_alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  fl;
        case (f)
            4'h0: begin r = a + b;  fl = 4'b1000; end
            4'h1: begin r = a - b;  fl = 4'b1000; end
            4'h2: begin r = a * b;  fl = 4'b1000; end
            4'h3: begin r = a & b;  fl = 4'b0100; end
            4'h4: begin r = a | b;  fl = 4'b0100; end
            4'h5: begin r = a ^ b;  fl = 4'b0100; end
            4'h6: begin r = ~a;     fl = 4'b0100; end
            4'h7: begin r = a & ~b; fl = 4'b0100; end
            4'h8: begin r = ~(a | b); fl = 4'b0100; end
            4'h9: begin r = ~(a & b); fl = 4'b0100; end
            4'hA: begin r = (a == b) ? 16'h0001 : 16'h0000; fl = 4'b0010; end
            4'hB: begin r = (a < b)  ? 16'h0001 : 16'h0000; fl = 4'b0010; end
            4'hC: begin r = (a > b)  ? 16'h0001 : 16'h0000; fl = 4'b0010; end
            4'hD: begin r = a >> ({1'b0, b[3:0]} + 5'd1); fl = 4'b0001; end
            4'hE: begin r = a << b[3:0]; fl = 4'b0001; end
            default: begin r = 16'h0000; fl = 4'b0000; end
        endcase
        return {fl, r};
    endfunction

    // Registered ALU: result valid one clock after operands are applied.
    always @(posedge clk) begin
        {alu_flags, alu_out} <= ref_alu(alu_fun, alu_a, alu_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: frame progress, countdown to response, response queue.
    int          m_cnt = 0;
    int          m_idle = 0;
    int          m_wait = 0;
    logic [7:0]  m_resp[$];
    logic [15:0] m_a = 16'h0000, m_b = 16'h0000;
    logic [3:0]  m_fun = 4'h0;
    bit          m_ovr = 1'b0, m_ferr = 1'b0;

    // At each falling edge: compare DUT to model, record accepted bytes, then
    // advance the model with the inputs the next rising edge will sample.
    always @(negedge clk) begin
        logic [19:0] r;
        logic        ev;
        ev = (m_resp.size() > 0);
        if (mdl_on) begin
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_fun", 32'(alu_fun), 32'(m_fun));
            chk("tx_valid", 32'(tx_valid), 32'(ev));
            if (ev) chk("tx_data", 32'(tx_data), 32'(m_resp[0]));
            chk("busy", 32'(busy), 32'((m_cnt > 0) || (m_wait > 0) || ev));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
        end
        if (frame_err) ferr_seen++;
        if (tx_valid && tx_ready && !rst) got.push_back(tx_data);

        if (rst) begin
            m_cnt = 0; m_idle = 0; m_wait = 0; m_resp.delete();
            m_a = 16'h0000; m_b = 16'h0000; m_fun = 4'h0;
            m_ovr = 1'b0; m_ferr = 1'b0;
        end else begin
            m_ferr = 1'b0;
            if (m_resp.size() > 0) begin
                if (rx_valid) m_ovr = 1'b1;
                if (tx_ready) void'(m_resp.pop_front());
            end else if (m_wait > 0) begin
                if (rx_valid) m_ovr = 1'b1;
                m_wait--;
                if (m_wait == 0) begin
                    r = ref_alu(m_fun, m_a, m_b);
                    m_resp.push_back(r[7:0]);
                    m_resp.push_back(r[15:8]);
                    m_resp.push_back({4'b0000, r[19:16]});
                end
            end else if (m_cnt > 0) begin
                if (rx_valid) begin
                    case (m_cnt)
                        1: m_a[7:0]  = rx_data;
                        2: m_a[15:8] = rx_data;
                        3: m_b[7:0]  = rx_data;
                        default: m_b[15:8] = rx_data;
                    endcase
                    m_idle = 0;
                    m_cnt++;
                    if (m_cnt == 5) begin
                        m_cnt = 0;
                        m_wait = 2;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_cnt = 0; m_idle = 0; m_ferr = 1'b1;
                    end
                end
            end else if (rx_valid) begin
                m_fun = rx_data[3:0];
                m_cnt = 1;
                m_idle = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first n bytes of fr (MSB byte first) with gap idle cycles between.
    task automatic send_frame(input logic [39:0] fr, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rx_data  = fr[39 - 8*i -: 8];
            rx_valid = 1'b1;
            tick(1);
            rx_valid = 1'b0;
            if (i < n - 1) tick(gap);
        end
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        @(negedge clk);
        while (!tx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!tx_valid) begin
            fails++;
            tests++;
            $display("FAIL %s: tx_valid never rose, got 0, expected 1", nm);
        end
    endtask

    task automatic expect_resp(input string nm, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        int k = 0;
        while (got.size() < 3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < 3) begin
            tests++;
            fails++;
            $display("FAIL %s: only %0d response bytes, expected 3", nm, got.size());
        end else begin
            chk({nm, "_b0"}, 32'(got[0]), 32'(e0));
            chk({nm, "_b1"}, 32'(got[1]), 32'(e1));
            chk({nm, "_b2"}, 32'(got[2]), 32'(e2));
        end
        got.delete();
        tick(1);
    endtask

    initial begin
        int quiet;
        int f0;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet = 0;
        int f0;
        tick(3);
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_fun", 32'(alu_fun), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_on = 1'b1;
        tick(2);

        // Add: result must appear exactly two cycles after the last byte.
        got.delete();
        send_frame(40'h00_05_00_0A_00, 5, 0);
        @(negedge clk); chk("lat_p0", 32'(tx_valid), 32'h0);
        @(negedge clk); chk("lat_p1", 32'(tx_valid), 32'h0);
        @(negedge clk); chk("lat_p2", 32'(tx_valid), 32'h1);
        expect_resp("add", 8'h0F, 8'h00, 8'h08);

        // Backpressure holds the first byte steady.
        tx_ready = 1'b0;
        send_frame(40'h02_04_00_08_00, 5, 0);
        wait_valid("mul");
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(tx_valid), 32'h1);
            chk("hold_data", 32'(tx_data), 32'h20);
            @(negedge clk);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_resp("mul", 8'h20, 8'h00, 8'h08);

        send_frame(40'h0A_05_00_05_00, 5, 0);
        expect_resp("cmp", 8'h01, 8'h00, 8'h02);
        send_frame(40'hFD_07_00_00_00, 5, 0);
        expect_resp("shift", 8'h03, 8'h00, 8'h01);

        // A byte arriving on the last permitted idle cycle is still accepted.
        f0 = ferr_seen;
        send_frame(40'h03_FF_00_0F_0F, 5, TO - 1);
        expect_resp("gap_edge", 8'h0F, 8'h00, 8'h04);
        chk("gap_no_ferr", 32'(ferr_seen - f0), 32'h0);

        // Partial frame then silence: one abort pulse, no response.
        f0 = ferr_seen;
        got.delete();
        send_frame(40'h00_05_00_00_00, 2, 0);
        for (int i = 0; i < TO + 5; i++) @(negedge clk);
        chk("to_ferr_pulses", 32'(ferr_seen - f0), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_no_tx", 32'(got.size()), 32'h0);
        chk("to_keep_a", 32'(alu_a), 32'h0005);
        @(posedge clk); #1;
        send_frame(40'h00_05_00_0A_00, 5, 0);
        expect_resp("after_to", 8'h0F, 8'h00, 8'h08);

        // Extra byte during SEND1 sets sticky overrun only.
        tx_ready = 1'b0;
        send_frame(40'h00_05_00_0A_00, 5, 0);
        wait_valid("ovr");
        @(posedge clk); #1;
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_send1", 32'(tx_data), 32'h00);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        expect_resp("ovr", 8'h0F, 8'h00, 8'h08);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(overrun), 32'h0);
        @(posedge clk); #1;

        // Reset in GET_B0 discards the partial frame.
        send_frame(40'h01_10_00_00_00, 3, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_a", 32'(alu_a), 32'h0);
        chk("mid_rst_fun", 32'(alu_fun), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        @(posedge clk); #1;
        got.delete();
        send_frame(40'h01_10_00_0C_00, 5, 0);
        expect_resp("after_rst", 8'h04, 8'h00, 8'h08);

        // Random traffic against the model.
        for (int c = 0; c < 5000; c++) begin
            if (quiet > 0) begin
                rx_valid = 1'b0;
                quiet--;
            end else begin
                rx_valid = ($urandom_range(0, 1) == 1);
                rx_data  = 8'($urandom);
                if ($urandom_range(0, 40) == 0) quiet = $urandom_range(TO - 2, TO + 2);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 600) == 0);
            tick(1);
        end
        rst = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
